// File: rtl/ins_loader.sv
// ins_loader: boot-time program loader feeding the byte write port of the
// byte-addressed instruction bank. Accepts an 8-bit valid/ready stream:
//   length N (16-bit word count, high byte first), then 4*N payload bytes,
// written big-endian so word k byte j lands at BASE + 4k + j.
// The processor is held in reset while loading and on error.
//
// Optional feature: define INS_LOADER_CHECKSUM_EN to expect one trailing byte
// equal to the XOR of all payload bytes; a mismatch ends in the error state.
//
// Parameters: ADDR_W byte address width (bank depth 2^ADDR_W),
//             BASE first byte address (multiple of 4).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             arms a load from idle/done/error
//   in_data/in_valid  stream byte and its valid
//   in_ready          loader takes a byte this cycle (from state only)
//   wr_en/wr_addr/wr_data  registered bank byte write
//   cpu_hold          keep processor in reset
//   done / error      image fully written / length overflow or bad checksum
module ins_loader #(
  parameter int ADDR_W = 8,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR, S_CSUM
  } state_t;

`ifdef INS_LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CSUM;
`else
  localparam state_t S_END = S_DONE;
`endif

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
  // Bytes available from BASE to the top of the bank.
  localparam logic [31:0] SPACE = 32'((64'd1 << ADDR_W) - 64'(BASE));

  state_t            state, state_next;
  logic [7:0]        len_hi;
  logic [17:0]       nbytes;
  logic [ADDR_W:0]   cnt;
  logic              accept;
  logic              armable;
  logic [15:0]       n_full;
  logic [17:0]       prod;
  logic              too_long;
  logic              last_byte;
`ifdef INS_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign in_ready  = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                     (state == S_DATA)   || (state == S_CSUM);
  assign accept    = in_valid && in_ready;
  assign armable   = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  assign n_full    = {len_hi, in_data};
  assign prod      = {n_full, 2'b00};
  assign too_long  = {14'd0, prod} > SPACE;
  assign last_byte = 32'(cnt) == ({14'd0, nbytes} - 32'd1);

  assign cpu_hold  = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERR);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_next = S_LEN_HI;
      S_LEN_HI: if (accept) state_next = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (n_full == 16'd0) state_next = S_END;
          else if (too_long)   state_next = S_ERR;
          else                 state_next = S_DATA;
        end
      end
      S_DATA: if (accept && last_byte) state_next = S_END;
`ifdef INS_LOADER_CHECKSUM_EN
      S_CSUM: if (accept) state_next = (in_data == csum) ? S_DONE : S_ERR;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      cnt     <= '0;
      len_hi  <= '0;
      nbytes  <= '0;
`ifdef INS_LOADER_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      if (armable && start) begin
        cnt  <= '0;
`ifdef INS_LOADER_CHECKSUM_EN
        csum <= '0;
`endif
      end
      if (state == S_LEN_HI && accept) len_hi <= in_data;
      if (state == S_LEN_LO && accept) nbytes <= prod;
      if (state == S_DATA && accept) begin
        wr_en   <= 1'b1;
        wr_addr <= BASE_A + cnt[ADDR_W-1:0];
        wr_data <= in_data;
        cnt     <= cnt + 1'b1;
`ifdef INS_LOADER_CHECKSUM_EN
        csum    <= csum ^ in_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ins_loader.sv
module tb_ins_loader;
  localparam int ADDR_W = 8;
  localparam int BASE   = 0;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              reset;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              cpu_hold;
  logic              done;
  logic              error;

  ins_loader #(.ADDR_W(ADDR_W), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  typedef struct { int unsigned addr; int unsigned data; } wr_t;
  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [7:0]  bank_obs[DEPTH];
  logic [7:0]  bank_ref[DEPTH];
  logic [7:0]  pay[$];
  int unsigned wr_seen = 0;
  bit          last_is_final = 0;

  // Observed bank: every strobe is matched against the planned write list.
  always @(posedge clk) begin
    #1;
    if (wr_en) begin
      wr_seen++;
      bank_obs[wr_addr] = wr_data;
      if (exp_q.size() == 0) check("spurious_wr", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", wr_addr, mon_e.addr);
        check("wr_data", wr_data, mon_e.data);
`ifndef INS_LOADER_CHECKSUM_EN
        if (exp_q.size() == 0 && last_is_final) begin
          check("done_with_last_wr", done, 1);
          check("hold_drop_with_last_wr", cpu_hold, 0);
        end
`endif
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int  cyc = 0;
    bit  acc = 0;
    while (!acc && cyc < 200) begin
      in_valid = ($urandom_range(99) >= gap);
      in_data  = in_valid ? b : 8'($urandom);
      acc      = in_valid && in_ready;
      tick();
      cyc++;
    end
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < DEPTH; i++) check(tag, bank_obs[i], bank_ref[i]);
  endtask

  // cut >= 0: assert reset after that many payload bytes have been accepted.
  task automatic run_load(input logic [15:0] n, input int gap, input int cut, input bit bad_csum);
    int unsigned nb   = 4 * n;
    bit          ovf  = nb > (DEPTH - BASE);
    logic [7:0]  s[$];
    logic [7:0]  x    = 8'h00;
    int unsigned w0;
    int          nsend;
    bit          exp_done;
    s.push_back(n[15:8]);
    s.push_back(n[7:0]);
    if (!ovf) begin
      for (int i = 0; i < int'(nb); i++) begin
        s.push_back(pay[i]);
        x ^= pay[i];
      end
`ifdef INS_LOADER_CHECKSUM_EN
      s.push_back(bad_csum ? (x ^ 8'h01) : x);
`endif
    end
    nsend = (cut >= 0) ? cut : (ovf ? 0 : int'(nb));
    for (int i = 0; i < nsend; i++) begin
      exp_q.push_back('{addr: BASE + i, data: pay[i]});
      bank_ref[BASE + i] = pay[i];
    end
    last_is_final = (cut < 0) && !ovf;
    exp_done = !ovf && !bad_csum;

    start = 1'b1;
    tick();
    start = 1'b0;
    check("armed_ready", in_ready, 1);
    check("armed_done_clr", done, 0);
    check("armed_err_clr", error, 0);
    w0 = wr_seen;

    for (int i = 0; i < s.size(); i++) begin
      if (cut >= 0 && i == cut + 2) break;
      send_byte(s[i], gap);
    end
    in_valid = 1'b0;

    if (cut >= 0) begin
      reset = 1'b1;
      tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_cpu_hold", cpu_hold, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      reset = 1'b0;
      check("rst_writes", wr_seen - w0, cut);
      check("rst_pending", exp_q.size(), 0);
      exp_q.delete();
      tick();
      return;
    end

    tick();
    tick();
    check("end_ready", in_ready, 0);
    check("end_done", done, exp_done);
    check("end_error", error, !exp_done);
    check("end_hold", cpu_hold, !exp_done);
    check("end_pending", exp_q.size(), 0);
    check("end_writes", wr_seen - w0, ovf ? 0 : nb);
  endtask

  task automatic fill_pay(input int unsigned len);
    pay.delete();
    for (int unsigned i = 0; i < len; i++) pay.push_back(8'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      bank_obs[i] = 8'hEE;
      bank_ref[i] = 8'hEE;
    end
    tick(); tick();
    check("reset_in_ready", in_ready, 0);
    check("reset_wr_en", wr_en, 0);
    check("reset_wr_addr", wr_addr, 0);
    check("reset_wr_data", wr_data, 0);
    check("reset_cpu_hold", cpu_hold, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    reset = 1'b0;
    tick();
    check("idle_start_ignored_ready", in_ready, 0);

    // Reference image: first word 0x070004BC.
    fill_pay(20);
    pay[0] = 8'h07; pay[1] = 8'h00; pay[2] = 8'h04; pay[3] = 8'hBC;
    run_load(16'd5, 0, -1, 0);
    check("fetch_word0", {bank_obs[0], bank_obs[1], bank_obs[2], bank_obs[3]}, 32'h070004BC);
    run_load(16'd5, 45, -1, 0);
    check_bank("bank_n5");

    run_load(16'h0041, 0, -1, 0);   // 260 bytes > 256
    run_load(16'd0, 0, -1, 0);
    fill_pay(256);
    run_load(16'd64, 10, -1, 0);    // exactly fills the bank
    run_load(16'd65, 0, -1, 0);
    check_bank("bank_boundary");

    fill_pay(40);
    run_load(16'd10, 0, 6, 0);
    check_bank("bank_after_reset");
    run_load(16'd10, 20, -1, 0);
    check_bank("bank_reload");

    for (int it = 0; it < 8; it++) begin
      int unsigned n = $urandom_range(70);
      fill_pay(4 * n);
      run_load(16'(n), int'($urandom_range(50)), -1, 0);
    end
    check_bank("bank_random");

`ifdef INS_LOADER_CHECKSUM_EN
    pay.delete();
    pay.push_back(8'h01); pay.push_back(8'h02); pay.push_back(8'h03); pay.push_back(8'h04);
    run_load(16'd1, 0, -1, 0);
    run_load(16'd1, 0, -1, 1);
    check_bank("bank_csum");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ins_loader.md
# ins_loader

Boot-time program loader: the write side of the byte-addressed instruction bank. It accepts a program image as an 8-bit valid/ready byte stream and writes each byte into the bank's byte write port in big-endian order, so the bank's fetch returns `{mem[a], mem[a+1], mem[a+2], mem[a+3]}` as the instruction word. It holds the processor in reset while loading and reports completion or error.

## Interface
Parameters:
- `ADDR_W`, 8: byte address width; bank depth is 2^ADDR_W bytes.
- `BASE`, 0: first byte address written; must be a multiple of 4.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  pulse; arms a load when idle, done or in error.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  stream byte valid.
- `in_ready`  out  1  loader accepts byte this cycle.
- `wr_en`  out  1  bank byte write strobe.
- `wr_addr`  out  ADDR_W  bank byte address.
- `wr_data`  out  8  bank byte data.
- `cpu_hold`  out  1  keep processor in reset.
- `done`  out  1  sticky: image fully written.
- `error`  out  1  sticky: length overflow (or checksum mismatch).

## Operation
- Stream format: length N (16-bit word count, high byte first), then 4·N payload bytes, with word k byte j (j=0 MSB) at address BASE+4k+j.
- States: IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR (plus CSUM when configured).
- Transitions:
  - IDLE/DONE/ERR + `start` -> LEN_HI; clears `done`/`error` and the byte counter.
  - LEN_HI + accept -> LEN_LO.
  - LEN_LO + accept -> N=0: DONE (CSUM if configured); N·4 > 2^ADDR_W−BASE: ERR; else DATA.
  - DATA accept with counter = 4N−1 -> DONE (or CSUM).
- `start` in LEN_HI/LEN_LO/DATA/CSUM is ignored.
- Accept = `in_valid && in_ready`. `in_ready` = 1 only in LEN_HI, LEN_LO, DATA, CSUM.
- Byte counter is ADDR_W+1 bits, increments only on DATA accepts; `wr_addr` = BASE + counter, truncated to ADDR_W.
- Length check uses full 18-bit product N·4; no wrap-around write ever occurs.
- `cpu_hold` = 1 in every state except IDLE and DONE (held in ERR).
- `done` = 1 only in DONE; `error` = 1 only in ERR.
- Bank contents are never cleared by the loader; untouched addresses keep prior values.

## Timing
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cpu_hold`=0, `done`=0, `error`=0; state IDLE.
- Reset mid-load aborts at the next edge; bytes already written remain.
- Write latency: DATA byte accepted at edge t drives `wr_en`=1, `wr_addr`, `wr_data` registered, valid for the single cycle after t. Back-to-back accepts give back-to-back writes, one byte per cycle peak.
- `done` rises in the cycle after the final payload write's strobe cycle begins, i.e. same edge as last `wr_en` assertion; `cpu_hold` falls on that edge.
- `in_ready` drops the cycle after the final byte is accepted; no combinational path from `in_valid` to `in_ready`.
- Gaps (`in_valid`=0) stall without state change.
- `start` and an accept in the same cycle in DONE/ERR: start wins, byte not accepted (`in_ready`=0 there).

## Configuration
- `INS_LOADER_CHECKSUM_EN` defined: after payload (or after N=0), state CSUM accepts one byte. Running XOR is taken over all payload bytes, not length; equal -> DONE, unequal -> ERR. Bank writes already made stay.
- Undefined: no CSUM state; stream ends after last payload byte.

## Test plan
- Load N=5 (00 05 + 20 bytes 0x07,0x00,0x04,0xBC,...) at full rate, BASE=0 -> 20 writes at addresses 0..19 in order, data matches; `done`=1, `cpu_hold`=0; fetch at addr 0 returns 0x070004BC.
- Same image with random `in_valid` gaps -> identical write sequence, no duplicate or missing `wr_en`.
- N=0x0041 with ADDR_W=8 (260 bytes > 256) -> ERR after LEN_LO, zero writes, `error`=1, `cpu_hold`=1; `start` clears to LEN_HI.
- N=0 -> DONE immediately after LEN_LO, no writes.
- Reset asserted after 6 payload bytes -> all outputs 0 next cycle, addresses 0..5 written, 6+ untouched; fresh `start` reloads correctly.
- With `INS_LOADER_CHECKSUM_EN`: N=1, payload 01 02 03 04, csum 0x04 -> DONE; csum 0x05 -> ERR with 4 bytes written.
